// File: rtl/wb_rr_arb.sv
// Round-robin Wishbone arbiter: NM classic-cycle masters share one slave fabric.
// Ownership is granted one clock after a request in IDLE and held for the whole
// m_cyc_i window; one dead cycle separates consecutive owners.
// Optional feature macro: WB_ARB_TIMEOUT_EN. When it is defined, a stalled strobe
// is errored back to the owner after 2**TMO_W-1 clocks without ack/err.
module wb_rr_arb #(
  parameter int NM    = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int TMO_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM*AW-1:0]   m_adr_i,
  input  logic [NM*DW-1:0]   m_dat_i,
  input  logic [NM*DW/8-1:0] m_sel_i,
  output logic [DW-1:0]      m_dat_o,
  output logic [NM-1:0]      m_ack_o,
  output logic [NM-1:0]      m_err_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [AW-1:0]      s_adr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic [DW/8-1:0]    s_sel_o,
  input  logic [DW-1:0]      s_dat_i,
  input  logic               s_ack_i,
  input  logic               s_err_i,
  output logic [NM-1:0]      gnt_o
);

  localparam int SW = DW / 8;
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] gidx, gidx_nxt;   // index of the current owner
  logic [PW-1:0] ptr, ptr_nxt;     // last owner; search starts just above it
  logic [PW-1:0] win_idx;
  logic          win_found;
  logic          tmo_hit;

  // Rotating priority search: first requester from ptr+1 upward, wrapping.
  always_comb begin
    int cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int i = 1; i <= NM; i++) begin
      cand = (int'(ptr) + i) % NM;
      if (!win_found && m_cyc_i[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  // State register: FSM state, owner index and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gidx  <= '0;
      ptr   <= PW'(NM - 1);
    end else begin
      state <= state_nxt;
      gidx  <= gidx_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state logic: grant in IDLE, release when the owner drops cyc.
  always_comb begin
    state_nxt = state;
    gidx_nxt  = gidx;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = BUSY;
          gidx_nxt  = win_idx;
        end
      end
      BUSY: begin
        if (!m_cyc_i[gidx]) begin
          state_nxt = IDLE;
          ptr_nxt   = gidx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: combinational mux of the owner onto the fabric and back.
  always_comb begin
    m_dat_o = s_dat_i;
    m_ack_o = '0;
    m_err_o = '0;
    gnt_o   = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (state == BUSY) begin
      gnt_o[gidx]   = 1'b1;
      s_cyc_o       = m_cyc_i[gidx];
      s_stb_o       = m_cyc_i[gidx] & m_stb_i[gidx] & ~tmo_hit;
      s_we_o        = m_we_i[gidx];
      s_adr_o       = m_adr_i[gidx*AW +: AW];
      s_dat_o       = m_dat_i[gidx*DW +: DW];
      s_sel_o       = m_sel_i[gidx*SW +: SW];
      // A master that has dropped cyc has aborted; nothing is routed back to it.
      m_ack_o[gidx] = m_cyc_i[gidx] & s_ack_i;
      m_err_o[gidx] = m_cyc_i[gidx] & (s_err_i | tmo_hit);
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             stb_raw;

  assign stb_raw = (state == BUSY) & m_cyc_i[gidx] & m_stb_i[gidx];
  assign tmo_hit = (tmo_cnt == {TMO_W{1'b1}});

  // Stall counter: runs while the strobe waits, clears on response or timeout.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (tmo_hit || !stb_raw || s_ack_i || s_err_i) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule
